gpio_scan_ctrl: RTL and testbench

//  Wishbone master that sequences the 8-bit wb_gpio slave. It configures the direction register once after

---
 rtl/gpio_scan_ctrl.sv | 114 +++++++++++
 tb/tb_gpio_scan_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gpio_scan_ctrl.sv
// gpio_scan_ctrl: Wishbone master that configures, polls and drives an 8-bit wb_gpio slave, queueing input-change events
module gpio_scan_ctrl #(
  parameter logic [31:0] BASE_ADR = 32'hF000_4000,
  parameter logic [7:0]  DIR_INIT = 8'h0F,
  parameter int          SCAN_DIV = 1000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        out_req,
  input  logic [7:0]  out_val,
  output logic        out_busy,
  output logic        evt_valid,
  output logic [15:0] evt_data,
  input  logic        evt_ready,
  output logic        irq,
  output logic        ovf,
  output logic        err
);
  typedef enum logic [1:0] {CFG, IDLE, BUS, GAP} state_t;
  typedef enum logic [1:0] {OP_DIR, OP_OUT, OP_RD} op_t;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  op_t op;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic scan_pend, first_scan;
  logic [7:0] out_reg, last_in, chg;
  logic [15:0] fifo [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic ack, tmo, tick, launch, rd_ack, push, pop, wr_en;
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i[31:8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= CFG;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      CFG:     state_nxt = BUS;
      IDLE:    state_nxt = (out_busy || scan_pend) ? BUS : IDLE;
      BUS:     state_nxt = (ack || tmo) ? GAP : BUS;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    wbm_cyc_o = state == BUS;
    wbm_stb_o = state == BUS;
    evt_valid = cnt != 3'd0;
    irq       = cnt != 3'd0;
    evt_data  = fifo[rp];
    ack       = state == BUS && wbm_ack_i;
    tmo       = state == BUS && !wbm_ack_i && tcnt == TW'(TIMEOUT - 1);
    tick      = state != CFG && scnt == SW'(SCAN_DIV - 1);
    launch    = state != BUS && state_nxt == BUS;
    rd_ack    = ack && op == OP_RD;
    chg       = (wbm_dat_i[7:0] ^ last_in) & ~DIR_INIT;
    push      = rd_ack && !first_scan && chg != 8'h00;
    pop       = evt_valid && evt_ready;
    wr_en     = push && (cnt != 3'd4 || pop);
  end
  // Access kind is chosen at launch: dir write from CFG, else pending output write beats scan read
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_we_o   <= 1'b0;
      op         <= OP_DIR;
      scnt       <= '0;
      tcnt       <= '0;
      scan_pend  <= 1'b0;
      first_scan <= 1'b1;
      out_busy   <= 1'b0;
      out_reg    <= '0;
      last_in    <= '0;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (launch) begin
        wbm_adr_o <= BASE_ADR + (state == CFG ? 32'h8 : out_busy ? 32'h4 : 32'h0);
        wbm_dat_o <= {24'b0, state == CFG ? DIR_INIT : out_busy ? out_reg : 8'h00};
        wbm_we_o  <= state == CFG || out_busy;
        op        <= state == CFG ? OP_DIR : out_busy ? OP_OUT : OP_RD;
      end
      scnt      <= (state == CFG || tick) ? '0 : scnt + 1'b1;
      tcnt      <= state == BUS ? tcnt + 1'b1 : '0;
      scan_pend <= tick || (scan_pend && !(launch && state == IDLE && !out_busy));
      out_busy  <= out_busy ? !(ack && op == OP_OUT) : out_req;
      if (!out_busy && out_req) out_reg <= out_val;
      if (rd_ack) begin
        last_in    <= wbm_dat_i[7:0];
        first_scan <= 1'b0;
      end
      if (wr_en) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {2'b0, wr_en} - {2'b0, pop};
      ovf <= ovf || (push && !wr_en);
      err <= tmo;
    end
  always_ff @(posedge clk)
    if (wr_en) fifo[wp] <= {chg, wbm_dat_i[7:0]};
endmodule

// File: tb/tb_gpio_scan_ctrl.sv
// tb_gpio_scan_ctrl: directed bench for gpio_scan_ctrl against a small wb_gpio slave model
module tb_gpio_scan_ctrl;
  localparam logic [31:0] BASE = 32'hF000_4000;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;
  logic out_req = 1'b0, out_busy, evt_valid, evt_ready = 1'b0, irq, ovf, err;
  logic [7:0] out_val = 8'h00;
  logic [15:0] evt_data;
  logic ack_en = 1'b1, ack_r = 1'b0;
  logic [7:0] pins = 8'h00;
  int errors = 0, checks = 0, rd_cnt = 0;
  typedef struct {logic [31:0] adr; logic we; logic [7:0] dat;} txn_t;
  txn_t tq[$];
  typedef struct {logic [7:0] pins; logic exp_valid; logic [15:0] exp_data;} vec_t;
  vec_t vecs[7];

  gpio_scan_ctrl #(.BASE_ADR(BASE), .DIR_INIT(8'h0F), .SCAN_DIV(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i),
    .out_req(out_req), .out_val(out_val), .out_busy(out_busy), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_ready(evt_ready), .irq(irq), .ovf(ovf), .err(err));

  always #5 clk = ~clk;
  // wb_gpio acks on the second cycle of stb
  always @(posedge clk) ack_r <= ack_en && wbm_cyc_o && wbm_stb_o && !ack_r;
  assign wbm_ack_i = ack_r;
  assign wbm_dat_i = {24'b0, pins};
  always @(posedge clk)
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      tq.push_back('{wbm_adr_o, wbm_we_o, wbm_dat_o[7:0]});
      if (!wbm_we_o) rd_cnt++;
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_read(input string name);
    int s = rd_cnt;
    int i = 0;
    while (rd_cnt == s && i < 40) begin step(); i++; end
    chk(name, 32'(rd_cnt != s), 1);
  endtask
  task automatic wait_txn(input int n, input string name);
    int i = 0;
    while (tq.size() < n && i < 60) begin step(); i++; end
    chk(name, 32'(tq.size() >= n), 1);
  endtask

  initial begin
    int n, len, i;
    logic [31:0] adr_to;
    vecs[0] = '{8'h00, 1'b0, 16'h0000};
    vecs[1] = '{8'h10, 1'b1, 16'h1010};
    vecs[2] = '{8'h11, 1'b0, 16'h0000};
    vecs[3] = '{8'h11, 1'b0, 16'h0000};
    vecs[4] = '{8'h81, 1'b1, 16'h9081};
    vecs[5] = '{8'h8F, 1'b0, 16'h0000};
    vecs[6] = '{8'h0F, 1'b1, 16'h800F};
    #2 rst = 1'b0;
    repeat (2) step();
    chk("rst_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_stb", 32'(wbm_stb_o), 0);
    chk("rst_we", 32'(wbm_we_o), 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_busy", 32'(out_busy), 0);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b1;
    step();
    chk("cfg_cyc", 32'(wbm_cyc_o), 1);
    chk("cfg_adr", wbm_adr_o, BASE + 32'h8);
    chk("cfg_dat", wbm_dat_o, 32'h0F);
    chk("cfg_we", 32'(wbm_we_o), 1);
    step();
    chk("cfg_cyc2", 32'(wbm_stb_o), 1);
    step();
    chk("cfg_gap", 32'(wbm_cyc_o), 0);
    chk("cfg_txns", tq.size(), 1);
    for (int k = 0; k < 7; k++) begin
      pins = vecs[k].pins;
      wait_read($sformatf("rd%0d_done", k));
      chk($sformatf("rd%0d_valid", k), 32'(evt_valid), 32'(vecs[k].exp_valid));
      chk($sformatf("rd%0d_irq", k), 32'(irq), 32'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        chk($sformatf("rd%0d_data", k), 32'(evt_data), 32'(vecs[k].exp_data));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk($sformatf("rd%0d_pop", k), 32'(irq), 0);
      end
    end
    // land out_req on the cycle the next scan tick fires
    wait_read("align");
    repeat (4) step();
    out_req = 1'b1;
    out_val = 8'hA5;
    tq.delete();
    step();
    out_req = 1'b0;
    n = 0;
    i = 0;
    while (tq.size() < 2 && i < 20) begin
      if (out_busy) n++;
      step();
      i++;
    end
    chk("prio_txns", tq.size(), 2);
    if (tq.size() >= 2) begin
      chk("prio_wr_adr", tq[0].adr, BASE + 32'h4);
      chk("prio_wr_we", 32'(tq[0].we), 1);
      chk("prio_wr_dat", 32'(tq[0].dat), 32'hA5);
      chk("prio_rd_adr", tq[1].adr, BASE);
      chk("prio_rd_we", 32'(tq[1].we), 0);
    end
    chk("busy_len", 32'(n >= 1 && n <= 4), 1);
    ack_en = 1'b0;
    out_req = 1'b1;
    out_val = 8'h3C;
    step();
    out_req = 1'b0;
    i = 0;
    while (!wbm_cyc_o && i < 30) begin step(); i++; end
    adr_to = wbm_adr_o;
    len = 0;
    while (wbm_cyc_o && len < 40) begin len++; step(); end
    chk("to_len", len, 16);
    chk("to_adr", adr_to, BASE + 32'h4);
    chk("to_err", 32'(err), 1);
    chk("to_busy", 32'(out_busy), 1);
    step();
    chk("to_err_pulse", 32'(err), 0);
    ack_en = 1'b1;
    tq.delete();
    wait_txn(1, "retry_done");
    if (tq.size() >= 1) begin
      chk("retry_adr", tq[0].adr, BASE + 32'h4);
      chk("retry_dat", 32'(tq[0].dat), 32'h3C);
    end
    chk("retry_busy", 32'(out_busy), 0);
    for (int j = 0; j < 5; j++) begin
      pins = j[0] ? 8'h0F : 8'h1F;
      wait_read($sformatf("ovf_rd%0d", j));
      if (j == 3) chk("ovf_before", 32'(ovf), 0);
    end
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_valid", 32'(evt_valid), 1);
    chk("ovf_head", 32'(evt_data), 32'h101F);
    i = 0;
    while (!wbm_cyc_o && i < 30) begin step(); i++; end
    chk("mid_rd_cyc", 32'(wbm_cyc_o), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cyc", 32'(wbm_cyc_o), 0);
    chk("arst_stb", 32'(wbm_stb_o), 0);
    chk("arst_valid", 32'(evt_valid), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_ovf", 32'(ovf), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
